// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: widths, ALU opcodes and the
// sequencing FSM state encoding.
package calc_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU; unsupported opcodes produce zero.
module ALU
  import calc_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   y
);

  // Opcode decode; ADD/SUB wrap at W bits.
  always_comb begin
    y = {W{1'b0}};
    case (op)
      OPW'(OP_ADD): y = a + b;
      OPW'(OP_SUB): y = a - b;
      OPW'(OP_AND): y = a & b;
      OPW'(OP_OR):  y = a | b;
      OPW'(OP_NOT): y = ~a;
      default:      y = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin front end for the shared ALU: accepts one transaction from two
// requesters, executes it, and holds a tagged response until it is consumed.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_err
);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic           id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_err_q, rsp_err_d;

  logic           grant0_s, grant1_s;
  logic           err_s;
  logic [W-1:0]   alu_y_s;

  ALU #(.W(W), .OPW(OPW)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y_s)
  );

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    grant0_s = req0_valid && (!req1_valid || last_grant_q);
    grant1_s = req1_valid && (!req0_valid || !last_grant_q);
    err_s    = (op_q > OPW'(OP_NOT));
  end

  assign req0_ready = !rst && (state_q == ST_IDLE) && grant0_s;
  assign req1_ready = !rst && (state_q == ST_IDLE) && grant1_s;

  // Next-state and datapath update for the accept / execute / respond sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready) begin
          a_d          = req0_a;
          b_d          = req0_b;
          op_d         = req0_op;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (req1_ready) begin
          a_d          = req1_a;
          b_d          = req1_b;
          op_d         = req1_op;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_err_d    = err_s;
        rsp_result_d = err_s ? {W{1'b0}} : alu_y_s;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset discards any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      op_q         <= {OPW{1'b0}};
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {W{1'b0}};
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule
